// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the response-mux FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLAVE = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } mux_state_e;

endpackage

// File: rtl/ahb_onehot_mux.sv
// One-hot AND-OR selector over N lanes of width W.
module ahb_onehot_mux #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++)
      dout = dout | (din[i*W +: W] & {W{sel[i]}});
  end

endmodule

// File: rtl/ahblite_slave_mux_n.sv
// AHB-Lite data-phase response mux with default slave and sticky error.
// Optional stall watchdog enabled by AHB_MUX_TIMEOUT_EN.
module ahblite_slave_mux_n
  import ahb_pkg::*;
#(
  parameter int NUM_PORTS      = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        HREADY,
  input  logic [1:0]                  HTRANS,
  input  logic [NUM_PORTS-1:0]        P_HSEL,
  input  logic [NUM_PORTS-1:0]        P_HREADYOUT,
  input  logic [NUM_PORTS-1:0]        P_HRESP,
  input  logic [NUM_PORTS*DATA_W-1:0] P_HRDATA,
  input  logic                        ERR_CLR,
  output logic                        HREADYOUT,
  output logic                        HRESP,
  output logic [DATA_W-1:0]           HRDATA,
`ifdef AHB_MUX_TIMEOUT_EN
  output logic                        DEC_ERR,
  output logic                        TIMEOUT_ERR
`else
  output logic                        DEC_ERR
`endif
);

  mux_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] sel_q, sel_d;
  logic                 rdy_m, resp_m;
  logic [DATA_W-1:0]    data_m;
  logic                 hsel_one, active, to_hit;
  logic                 dec_err_q;

  assign active   = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign hsel_one = (|P_HSEL) &&
                    ~|(P_HSEL & (P_HSEL - NUM_PORTS'(1)));

  ahb_onehot_mux #(.N(NUM_PORTS), .W(1)) u_rdy (
    .sel  (sel_q),
    .din  (P_HREADYOUT),
    .dout (rdy_m)
  );

  ahb_onehot_mux #(.N(NUM_PORTS), .W(1)) u_resp (
    .sel  (sel_q),
    .din  (P_HRESP),
    .dout (resp_m)
  );

  ahb_onehot_mux #(.N(NUM_PORTS), .W(DATA_W)) u_data (
    .sel  (sel_q),
    .din  (P_HRDATA),
    .dout (data_m)
  );

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;
  logic          to_err_q;

  // Abandon the slave on the last allowed stall cycle
  assign to_hit = (state_q == ST_SLAVE) && !rdy_m &&
                  (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      if ((state_q == ST_SLAVE) && !rdy_m && (state_d == ST_SLAVE))
        to_cnt_q <= to_cnt_q + CW'(1);
      else
        to_cnt_q <= '0;
      to_err_q <= to_hit | (to_err_q & ~ERR_CLR);
    end
  end

  assign TIMEOUT_ERR = to_err_q;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (to_hit) begin
      state_d = ST_ERR1;
      sel_d   = '0;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (HREADY) begin
      unique case (1'b1)
        hsel_one: begin
          state_d = ST_SLAVE;
          sel_d   = P_HSEL;
        end
        !hsel_one && active: begin
          state_d = ST_ERR1;
          sel_d   = '0;
        end
        !hsel_one && !active: begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      dec_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dec_err_q <= (state_d == ST_ERR1) | (dec_err_q & ~ERR_CLR);
    end
  end

  assign DEC_ERR = dec_err_q;

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    unique case (state_q)
      ST_IDLE: ;
      ST_SLAVE: begin
        HREADYOUT = rdy_m;
        HRESP     = resp_m;
        HRDATA    = data_m;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_ERROR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahblite_slave_mux_n.sv
// Bench for ahblite_slave_mux_n: transfer-level model plus directed checks.
module tb_ahblite_slave_mux_n;

  localparam int NP = 8;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef AHB_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             HCLK = 1'b0;
  logic             HRESET, HREADY, ERR_CLR;
  logic [1:0]       HTRANS;
  logic [NP-1:0]    P_HSEL, P_HREADYOUT, P_HRESP;
  logic [NP*DW-1:0] P_HRDATA;
  logic             HREADYOUT, HRESP, DEC_ERR;
  logic [DW-1:0]    HRDATA;
  logic             to_err;

  always #5 HCLK = ~HCLK;

  // single-layer bus: master ready is the mux output
  assign HREADY = HREADYOUT;

  ahblite_slave_mux_n #(
    .NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HREADY      (HREADY),
    .HTRANS      (HTRANS),
    .P_HSEL      (P_HSEL),
    .P_HREADYOUT (P_HREADYOUT),
    .P_HRESP     (P_HRESP),
    .P_HRDATA    (P_HRDATA),
    .ERR_CLR     (ERR_CLR),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
`ifdef AHB_MUX_TIMEOUT_EN
    .DEC_ERR     (DEC_ERR),
    .TIMEOUT_ERR (to_err)
`else
    .DEC_ERR     (DEC_ERR)
`endif
  );

`ifndef AHB_MUX_TIMEOUT_EN
  assign to_err = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: which port owns the data phase (-1 none), error phase 0/1/2
  int m_port  = -1;
  int m_err   = 0;
  int m_stall = 0;
  bit m_dec   = 0;
  bit m_to    = 0;
  bit chk_en  = 0;

  function automatic int idx_of(logic [NP-1:0] s);
    int r = -1;
    for (int i = 0; i < NP; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic logic exp_rdy();
    if (m_err == 1) return 1'b0;
    if (m_err == 2) return 1'b1;
    if (m_port >= 0) return P_HREADYOUT[m_port];
    return 1'b1;
  endfunction

  function automatic logic exp_resp();
    if (m_err != 0) return 1'b1;
    if (m_port >= 0) return P_HRESP[m_port];
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    if (m_err == 0 && m_port >= 0) return P_HRDATA[m_port*DW +: DW];
    return '0;
  endfunction

  always @(posedge HCLK) begin : mdl
    int np, ne, ns, n;
    bit st, tt, stalled;
    np = m_port; ne = m_err; ns = 0; st = 0; tt = 0;
    stalled = (m_err == 0) && (m_port >= 0) && !P_HREADYOUT[m_port];
    if (!HRESET) begin
      ns = stalled ? m_stall + 1 : 0;
      if (m_err == 1) begin
        ne = 2;
      end else if (TO_EN && stalled && m_stall == TO - 1) begin
        np = -1; ne = 1; st = 1; tt = 1; ns = 0;
      end else if (exp_rdy()) begin
        n = $countones(P_HSEL);
        np = (n == 1) ? idx_of(P_HSEL) : -1;
        ne = (n != 1 && HTRANS[1]) ? 1 : 0;
        st = (ne == 1);
      end
    end else begin
      np = -1; ne = 0;
    end
    m_port  <= np;
    m_err   <= ne;
    m_stall <= ns;
    m_dec   <= !HRESET && (st || (m_dec && !ERR_CLR));
    m_to    <= !HRESET && (tt || (m_to && !ERR_CLR));
    if (HRESET) chk_en <= 1'b1;
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("mdl_hreadyout", 32'(HREADYOUT), 32'(exp_rdy()));
      chk("mdl_hresp", 32'(HRESP), 32'(exp_resp()));
      chk("mdl_hrdata", HRDATA, exp_data());
      chk("mdl_dec_err", 32'(DEC_ERR), 32'(m_dec));
      chk("mdl_timeout_err", 32'(to_err), 32'(m_to));
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic lit(string nm, logic r, logic p, logic [31:0] d);
    chk({nm, "_rdy"}, 32'(HREADYOUT), 32'(r));
    chk({nm, "_resp"}, 32'(HRESP), 32'(p));
    chk({nm, "_data"}, HRDATA, d);
  endtask

  initial begin
    HRESET = 1'b1; HTRANS = 2'b00; P_HSEL = '0;
    P_HREADYOUT = '1; P_HRESP = '0; ERR_CLR = 1'b0;
    for (int i = 0; i < NP; i++)
      P_HRDATA[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // reset then idle
    @(negedge HCLK);
    lit("reset", 1, 0, 0);
    chk("reset_dec", 32'(DEC_ERR), 0);

    // port 2 read with two wait states
    P_HSEL = 8'h04; HTRANS = 2'b10; P_HREADYOUT[2] = 1'b0;
    step();
    P_HSEL = '0; HTRANS = 2'b00;
    @(negedge HCLK) chk("rd_wait1", 32'(HREADYOUT), 0);
    step();
    @(negedge HCLK) chk("rd_wait2", 32'(HREADYOUT), 0);
    step();
    P_HREADYOUT[2] = 1'b1;
    @(negedge HCLK) lit("rd_done", 1, 0, 32'hA5A5_0002);
    step();

    // unmapped NONSEQ
    HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    @(negedge HCLK) lit("um_err1", 0, 1, 0);
    chk("um_dec", 32'(DEC_ERR), 1);
    step();
    @(negedge HCLK) lit("um_err2", 1, 1, 0);
    step();
    @(negedge HCLK) chk("um_sticky", 32'(DEC_ERR), 1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    @(negedge HCLK) chk("um_clr", 32'(DEC_ERR), 0);

    // multi-select SEQ: no data routed
    P_HSEL = 8'h81; HTRANS = 2'b11;
    step();
    P_HSEL = '0; HTRANS = 2'b00;
    @(negedge HCLK) lit("ms_err1", 0, 1, 0);
    step();
    @(negedge HCLK) lit("ms_err2", 1, 1, 0);
    step();
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;

    // set wins over clear
    HTRANS = 2'b10; ERR_CLR = 1'b1;
    step();
    HTRANS = 2'b00; ERR_CLR = 1'b0;
    @(negedge HCLK) chk("set_wins", 32'(DEC_ERR), 1);
    step();
    step();
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;

    // single select with HTRANS=IDLE still routes the slave
    P_HSEL = 8'h04;
    step();
    P_HSEL = '0;
    @(negedge HCLK) lit("idle_sel", 1, 0, 32'hA5A5_0002);
    step();

    // inactive multi-select goes idle quietly
    P_HSEL = 8'h30; HTRANS = 2'b01;
    step();
    P_HSEL = '0; HTRANS = 2'b00;
    @(negedge HCLK) lit("busy_multi", 1, 0, 0);
    chk("busy_multi_dec", 32'(DEC_ERR), 0);
    step();

    // back-to-back port1/port5 with no bubble
    P_HSEL = 8'h02; HTRANS = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      P_HSEL = (k % 2 == 0) ? 8'h20 : 8'h02;
      HTRANS = 2'b11;
      @(negedge HCLK);
      chk("b2b", HRDATA, (k % 2 == 0) ? 32'hA5A5_0001 : 32'hA5A5_0005);
      step();
    end
    P_HSEL = '0; HTRANS = 2'b00;
    @(negedge HCLK) lit("b2b_last", 1, 0, 32'hA5A5_0005);
    step();

`ifdef AHB_MUX_TIMEOUT_EN
    // watchdog: port 3 never ready
    P_HSEL = 8'h08; HTRANS = 2'b10; P_HREADYOUT[3] = 1'b0;
    step();
    P_HSEL = '0; HTRANS = 2'b00;
    for (int i = 0; i < TO; i++) begin
      @(negedge HCLK);
      chk("to_stall", {HREADYOUT, to_err}, 0);
      step();
    end
    @(negedge HCLK) lit("to_err1", 0, 1, 0);
    chk("to_flag", 32'(to_err), 1);
    chk("to_dec", 32'(DEC_ERR), 1);
    step();
    @(negedge HCLK) lit("to_err2", 1, 1, 0);
    step();
    P_HSEL = 8'h08; HTRANS = 2'b10;
    step();
    P_HSEL = '0; HTRANS = 2'b00;
    repeat (TO) step();
    @(negedge HCLK) lit("to_mid_err1", 0, 1, 0);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    P_HREADYOUT = '1;
    @(negedge HCLK) lit("to_reset", 1, 0, 0);
    chk("to_reset_flags", {DEC_ERR, to_err}, 0);
    step();
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_mux_n.md
Name: ahblite_slave_mux_n

Overview:
- Parametrised AHB-Lite data-phase response multiplexer for NUM_PORTS slaves.
- Sits between the address decoder and the master, returning the selected slave's HREADYOUT/HRESP/HRDATA.
- Adds an integrated default slave that gives a two-cycle ERROR for unmapped or multiply-selected active transfers.
- Adds a sticky decode-error status.

Parameters:
- NUM_PORTS, 8, number of slave ports (2..16).
- DATA_W, 32, HRDATA width.
- TIMEOUT_CYCLES, 256, stall limit for the optional watchdog (≥2).

Ports:
- HCLK  in  1  bus clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HREADY  in  1  bus-level ready; address phase accepted when high.
- HTRANS  in  2  current address-phase transfer type.
- P_HSEL  in  NUM_PORTS  decoder one-hot select, bit i = port i.
- P_HREADYOUT  in  NUM_PORTS  per-port ready.
- P_HRESP  in  NUM_PORTS  per-port response.
- P_HRDATA  in  NUM_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- ERR_CLR  in  1  clears sticky status.
- HREADYOUT  out  1  muxed ready to master.
- HRESP  out  1  muxed response.
- HRDATA  out  DATA_W  muxed read data.
- DEC_ERR  out  1  sticky: set on any default-slave ERROR.

Behaviour:
- Reset: state IDLE, sel_reg=0, HREADYOUT=1, HRESP=0, HRDATA=0, DEC_ERR=0. HRESET overrides all other inputs, including mid-ERROR; the next cycle is IDLE.
- Address-phase capture happens only when HREADY=1. active = HTRANS[1] (NONSEQ/SEQ).
- FSM states: IDLE, SLAVE, ERR1, ERR2. Transitions are evaluated only when HREADY=1, except ERR1→ERR2, which is unconditional.
  - popcount(P_HSEL)==1: sel_reg<=P_HSEL, go to SLAVE. This applies regardless of HTRANS; the slave handles IDLE/BUSY itself.
  - popcount==0 and active, or popcount>1 and active: go to ERR1, sel_reg<=0.
  - popcount==0 and not active: go to IDLE.
  - popcount>1 and not active: go to IDLE, sel_reg<=0.
- Outputs by state (combinational from state/sel_reg, no extra latency):
  - IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - SLAVE: outputs = fields of port i where sel_reg[i]=1.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=0.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=0; the next state is taken from the address phase presented in this cycle, i.e. the normal HREADY=1 decision.
- Stall: while in SLAVE with HREADY=0, sel_reg and state hold.
- DEC_ERR is set on entry to ERR1 and cleared by ERR_CLR. If set and clear occur in the same cycle, set wins.
- Back-to-back transfers: a new select captured in the same cycle the previous data phase completes takes effect next cycle with zero bubble.

Optional Feature:
- Macro AHB_MUX_TIMEOUT_EN.
- With the macro:
  - A counter tracks consecutive SLAVE cycles with selected HREADYOUT=0. It resets on any ready cycle or state change.
  - When the counter reaches TIMEOUT_CYCLES, the FSM forces ERR1 and ERR2 (stalled slave abandoned), sets DEC_ERR and sets output TIMEOUT_ERR (sticky, 1 bit, cleared by ERR_CLR).
  - Port TIMEOUT_ERR exists only in this configuration.
- Without the macro: no counter and no TIMEOUT_ERR port; SLAVE may stall indefinitely.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP_OKAY=0, HRESP_ERROR=1.
  - Mux FSM state encoding.
- One natural sub-module: ahb_onehot_mux. It is a parametrised one-hot AND-OR selector over NUM_PORTS lanes of width W, instantiated for ready, resp and data.

Test Plan:
- Reset then idle: hold HRESET 2 cycles, then HTRANS=IDLE with P_HSEL=0 → HREADYOUT=1, HRESP=0, HRDATA=0, DEC_ERR=0.
- Port read: P_HSEL=8'h04, NONSEQ, HREADY=1; next cycle port2 drives HRDATA=32'hA5A5_0002 with HREADYOUT=0 for 2 cycles then 1 → master sees 2 wait states, then that data with HRESP=0.
- Unmapped: P_HSEL=0, NONSEQ → next cycle HREADYOUT=0/HRESP=1, following cycle HREADYOUT=1/HRESP=1, DEC_ERR=1 until an ERR_CLR pulse.
- Multi-select: P_HSEL=8'h81, SEQ → same two-cycle ERROR, with no port data routed (HRDATA=0).
- Back-to-back: port1 then port5 on consecutive cycles with zero-wait slaves → HRDATA alternates port1/port5 values with no bubble.
- With AHB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=16: port3 holds HREADYOUT=0 → after 16 stall cycles ERR1 then ERR2, TIMEOUT_ERR=1 and DEC_ERR=1; a mid-ERR1 HRESET returns to IDLE with all flags 0.
